// File: rtl/muldiv_unit_pkg.sv
// Shared widths, RV32M funct3 encodings and FSM states
// for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  localparam int XLEN       = 32;
  localparam int HART_ID_W  = 1;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = $clog2(XLEN);

  localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Bit-serial RV32M multiply/divide unit shared by both harts.
// Fixed 33-edge latency from accepted start to the done pulse.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  muldiv_start,
  input  logic [2:0]            muldiv_op,
  input  logic [XLEN-1:0]       muldiv_a,
  input  logic [XLEN-1:0]       muldiv_b,
  input  logic [HART_ID_W-1:0]  muldiv_hart_id,
  input  logic [REG_ADDR_W-1:0] muldiv_rd,
  output logic                  muldiv_busy,
  output logic                  muldiv_done,
  output logic [XLEN-1:0]       muldiv_result,
  output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
  output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_n;

  logic [2:0]            op_q;
  logic                  neg_q;
  logic                  dz_q;
  logic                  ovf_q;
  logic [XLEN-1:0]       m_q;
  logic [2*XLEN-1:0]     acc_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [HART_ID_W-1:0]  hart_q;
  logic [REG_ADDR_W-1:0] rd_q;

  logic                  done_q;
  logic [XLEN-1:0]       res_q;
  logic [HART_ID_W-1:0]  done_hart_q;
  logic [REG_ADDR_W-1:0] done_rd_q;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic            in_div, in_neg, in_dz, in_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn = (muldiv_op == MULDIV_OP_MULH)
          | (muldiv_op == MULDIV_OP_MULHSU)
          | (muldiv_op == MULDIV_OP_DIV)
          | (muldiv_op == MULDIV_OP_REM);
    b_sgn = (muldiv_op == MULDIV_OP_MULH)
          | (muldiv_op == MULDIV_OP_DIV)
          | (muldiv_op == MULDIV_OP_REM);
    a_neg  = a_sgn & muldiv_a[XLEN-1];
    b_neg  = b_sgn & muldiv_b[XLEN-1];
    a_mag  = a_neg ? -muldiv_a : muldiv_a;
    b_mag  = b_neg ? -muldiv_b : muldiv_b;
    in_div = muldiv_op[2];
    in_dz  = in_div & (muldiv_b == '0);
    in_ovf = (muldiv_op == MULDIV_OP_DIV)
           & (muldiv_a == XMIN)
           & (muldiv_b == '1);
    // remainder follows the dividend; everything else the xor
    if (muldiv_op == MULDIV_OP_REM)
      in_neg = a_neg;
    else
      in_neg = a_neg ^ b_neg;
  end

  // one XLEN+1 adder: add for multiply, subtract for divide
  logic [XLEN:0]   add_a, add_b;
  logic            add_ci;
  logic [XLEN+1:0] add_s;
  logic            q_ok;
  logic [2*XLEN-1:0] acc_n;

  always_comb begin
    if (op_q[2]) begin
      add_a  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      add_b  = ~{1'b0, m_q};
      add_ci = 1'b1;
    end else begin
      add_a  = {1'b0, acc_q[2*XLEN-1:XLEN]};
      add_b  = acc_q[0] ? {1'b0, m_q} : '0;
      add_ci = 1'b0;
    end
    add_s = {1'b0, add_a} + {1'b0, add_b}
          + {{(XLEN+1){1'b0}}, add_ci};
    q_ok  = add_s[XLEN+1];
    if (op_q[2])
      acc_n = {q_ok ? add_s[XLEN-1:0] : add_a[XLEN-1:0],
               acc_q[XLEN-2:0], q_ok};
    else
      acc_n = {add_s[XLEN:0], acc_q[XLEN-1:1]};
  end

  logic [2*XLEN-1:0] fix64;
  logic [XLEN-1:0]   quo, rem, res_c;
  logic              is_lo, is_hi, is_quo, is_rem;

  always_comb begin
    fix64  = neg_q ? -acc_q : acc_q;
    quo    = acc_q[XLEN-1:0];
    rem    = acc_q[2*XLEN-1:XLEN];
    is_lo  = (op_q == MULDIV_OP_MUL);
    is_hi  = ~op_q[2] & ~is_lo;
    is_quo = op_q[2] & ~op_q[1];
    is_rem = op_q[2] & op_q[1];
    res_c  = '0;
    unique case (1'b1)
      is_lo:  res_c = quo;
      is_hi:  res_c = fix64[2*XLEN-1:XLEN];
      is_quo: res_c = dz_q  ? '1 :
                      ovf_q ? XMIN :
                      neg_q ? -quo : quo;
      is_rem: res_c = ovf_q ? '0 :
                      neg_q ? -rem : rem;
      default: res_c = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (muldiv_start) state_n = ST_CALC;
      ST_CALC: if (cnt_q == CNT_W'(XLEN-1)) state_n = ST_FIN;
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      m_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      hart_q      <= '0;
      rd_q        <= '0;
      done_q      <= 1'b0;
      res_q       <= '0;
      done_hart_q <= '0;
      done_rd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (muldiv_start) begin
            op_q   <= muldiv_op;
            neg_q  <= in_neg;
            dz_q   <= in_dz;
            ovf_q  <= in_ovf;
            m_q    <= in_div ? b_mag : a_mag;
            acc_q  <= {{XLEN{1'b0}}, in_div ? a_mag : b_mag};
            cnt_q  <= '0;
            hart_q <= muldiv_hart_id;
            rd_q   <= muldiv_rd;
          end
        end
        ST_CALC: begin
          acc_q <= acc_n;
          cnt_q <= cnt_q + 1'b1;
        end
        ST_FIN: begin
          res_q       <= res_c;
          done_q      <= 1'b1;
          done_hart_q <= hart_q;
          done_rd_q   <= rd_q;
        end
        default: ;
      endcase
    end
  end

  assign muldiv_busy         = (state != ST_IDLE);
  assign muldiv_done         = done_q;
  assign muldiv_result       = res_q;
  assign muldiv_done_hart_id = done_hart_q;
  assign muldiv_done_rd      = done_rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Vector table plus scoreboard for muldiv_unit, with
// handshake, back-to-back and mid-op reset sequences.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [2:0]            op = '0;
  logic [XLEN-1:0]       a = '0;
  logic [XLEN-1:0]       b = '0;
  logic [HART_ID_W-1:0]  hart = '0;
  logic [REG_ADDR_W-1:0] rd = '0;
  logic                  busy, done;
  logic [XLEN-1:0]       result;
  logic [HART_ID_W-1:0]  done_hart;
  logic [REG_ADDR_W-1:0] done_rd;

  muldiv_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .muldiv_start        (start),
    .muldiv_op           (op),
    .muldiv_a            (a),
    .muldiv_b            (b),
    .muldiv_hart_id      (hart),
    .muldiv_rd           (rd),
    .muldiv_busy         (busy),
    .muldiv_done         (done),
    .muldiv_result       (result),
    .muldiv_done_hart_id (done_hart),
    .muldiv_done_rd      (done_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [XLEN-1:0]       res;
    logic [HART_ID_W-1:0]  hart;
    logic [REG_ADDR_W-1:0] rd;
    int                    cyc;
  } exp_t;

  exp_t sb[$];

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done_hart", 32'(done_hart), 32'(e.hart));
        chk("done_rd", 32'(done_rd), 32'(e.rd));
        chk("latency", 32'(cyc), 32'(e.cyc));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // caller aligns to a negedge; start is sampled at the next posedge
  task automatic issue(input logic [2:0] o,
                       input logic [31:0] va,
                       input logic [31:0] vb,
                       input logic [HART_ID_W-1:0] h,
                       input logic [REG_ADDR_W-1:0] r,
                       input logic [31:0] ex);
    exp_t e;
    op = o; a = va; b = vb; hart = h; rd = r;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.res = ex; e.hart = h; e.rd = r;
    e.cyc = cyc + XLEN + 1;
    sb.push_back(e);
    chk("busy_after_start", 32'(busy), 32'd1);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [HART_ID_W-1:0]  hart;
    logic [REG_ADDR_W-1:0] rd;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{MULDIV_OP_MUL,    32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1, 5'd5};
    vecs[1]  = '{MULDIV_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 5'd1};
    vecs[2]  = '{MULDIV_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 5'd2};
    vecs[3]  = '{MULDIV_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd3};
    vecs[4]  = '{MULDIV_OP_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b1, 5'd4};
    vecs[5]  = '{MULDIV_OP_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 1'b0, 5'd6};
    vecs[6]  = '{MULDIV_OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b1, 5'd7};
    vecs[7]  = '{MULDIV_OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0, 5'd8};
    vecs[8]  = '{MULDIV_OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 5'd9};
    vecs[9]  = '{MULDIV_OP_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b0, 5'd10};
    vecs[10] = '{MULDIV_OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 5'd11};
    vecs[11] = '{MULDIV_OP_REMU,   32'd123,      32'd0,        32'd123,      1'b0, 5'd12};
    vecs[12] = '{MULDIV_OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 5'd13};
    vecs[13] = '{MULDIV_OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 5'd14};
    vecs[14] = '{MULDIV_OP_MULH,   32'd3,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 5'd15};
    vecs[15] = '{MULDIV_OP_MUL,    32'h10000,    32'h10000,    32'h0,        1'b0, 5'd16};
    vecs[16] = '{MULDIV_OP_MULHU,  32'h10000,    32'h10000,    32'h1,        1'b1, 5'd17};
    vecs[17] = '{MULDIV_OP_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0, 5'd18};
    vecs[18] = '{MULDIV_OP_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 1'b1, 5'd19};
    vecs[19] = '{MULDIV_OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 5'd0};

    // reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_hart", 32'(done_hart), 32'd0);
    chk("rst_rd", 32'(done_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      wait_drain();
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].hart, vecs[i].rd, vecs[i].exp);
    end
    wait_drain();

    // start while busy must be ignored
    @(negedge clk);
    issue(MULDIV_OP_DIVU, 32'd100, 32'd7, 1'b0, 5'd3, 32'd14);
    repeat (5) @(negedge clk);
    op = MULDIV_OP_MUL; a = 32'd9; b = 32'd9;
    hart = 1'b1; rd = 5'd30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // back-to-back: new start during the done cycle
    @(negedge clk);
    issue(MULDIV_OP_MUL, 32'd6, 32'd7, 1'b1, 5'd21, 32'd42);
    begin
      int k;
      k = 0;
      while (!done && k < 60) begin
        @(negedge clk);
        k++;
      end
      chk("b2b_done_seen", 32'(done), 32'd1);
    end
    issue(MULDIV_OP_REMU, 32'd50, 32'd8, 1'b0, 5'd22, 32'd2);
    wait_drain();

    // reset in the middle of an operation
    @(negedge clk);
    issue(MULDIV_OP_MULHU, 32'hFFFFFFFF, 32'h2, 1'b1, 5'd23, 32'h1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd", 32'(done_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    issue(MULDIV_OP_DIV, 32'hFFFFFF9C, 32'd7, 1'b1, 5'd24, 32'hFFFFFFF2);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
